// File: rtl/moe_topk_gate.sv
// moe_topk_gate
//   Picks the two largest signed logits out of a NUM_LANES-wide vector,
//   honouring a per-lane expert enable mask. One lane is examined per
//   cycle, so a result is always ready NUM_LANES cycles after acceptance.
//
//   Handshake: a transfer happens on a rising edge where valid && ready.
//   in_ready is high only in IDLE. out_valid stays high, with every result
//   output stable, until out_ready is seen. Data offered while in_ready is
//   low is ignored and latches the sticky err_drop flag.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid/in_sum/in_mask     input vector (lane i at [i*LANE_W +: LANE_W])
//   in_ready                    block is idle and will accept a vector
//   out_valid/out_ready         result handshake
//   out_idx0/1, out_score0/1    best / second-best expert (0 when slot empty)
//   out_cnt                     number of filled result slots (0..2)
//   err_drop                    sticky: an input vector was dropped
//   dbg_state                   current FSM state (0 IDLE, 1 SCAN, 2 DONE)
module moe_topk_gate #(
   parameter int NUM_LANES = 16,
   parameter int LANE_W    = 16,
   parameter int IDX_W     = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   input  logic [NUM_LANES*LANE_W-1:0] in_sum,
   input  logic [NUM_LANES-1:0]        in_mask,
   output logic                        in_ready,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [IDX_W-1:0]            out_idx0,
   output logic [IDX_W-1:0]            out_idx1,
   output logic [LANE_W-1:0]           out_score0,
   output logic [LANE_W-1:0]           out_score1,
   output logic [1:0]                  out_cnt,
   output logic                        err_drop,
   output logic [1:0]                  dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                      state;
   logic [NUM_LANES*LANE_W-1:0] vec_q;
   logic [NUM_LANES-1:0]        mask_q;
   logic [IDX_W-1:0]            idx;
   logic                        s0_v, s1_v;
   logic [IDX_W-1:0]            s0_idx, s1_idx;
   logic [LANE_W-1:0]           s0_score, s1_score;
   logic                        err_q;

   // Lane currently under examination.
   logic [LANE_W-1:0] lane_v;
   logic              lane_en;

   always_comb begin
      lane_v  = '0;
      lane_en = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (idx == IDX_W'(i)) begin
            lane_v  = vec_q[i*LANE_W +: LANE_W];
            lane_en = mask_q[i];
         end
      end
   end

   // Strict greater-than: an equal later lane never displaces an earlier one.
   logic beats_s0, beats_s1;
   assign beats_s0 = !s0_v || ($signed(lane_v) > $signed(s0_score));
   assign beats_s1 = !s1_v || ($signed(lane_v) > $signed(s1_score));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         vec_q    <= '0;
         mask_q   <= '0;
         idx      <= '0;
         s0_v     <= 1'b0;
         s1_v     <= 1'b0;
         s0_idx   <= '0;
         s1_idx   <= '0;
         s0_score <= '0;
         s1_score <= '0;
         err_q    <= 1'b0;
      end else begin
         if (in_valid && state != IDLE) err_q <= 1'b1;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  vec_q    <= in_sum;
                  mask_q   <= in_mask;
                  idx      <= '0;
                  s0_v     <= 1'b0;
                  s1_v     <= 1'b0;
                  s0_idx   <= '0;
                  s1_idx   <= '0;
                  s0_score <= '0;
                  s1_score <= '0;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               // Masked lanes still consume their cycle to keep latency fixed.
               if (lane_en) begin
                  if (beats_s0) begin
                     s1_v     <= s0_v;
                     s1_idx   <= s0_idx;
                     s1_score <= s0_score;
                     s0_v     <= 1'b1;
                     s0_idx   <= idx;
                     s0_score <= lane_v;
                  end else if (beats_s1) begin
                     s1_v     <= 1'b1;
                     s1_idx   <= idx;
                     s1_score <= lane_v;
                  end
               end
               idx <= idx + 1'b1;
               if (idx == IDX_W'(NUM_LANES - 1)) state <= DONE;
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready   = (state == IDLE);
   assign out_valid  = (state == DONE);
   assign out_idx0   = s0_v ? s0_idx : '0;
   assign out_idx1   = s1_v ? s1_idx : '0;
   assign out_score0 = s0_v ? s0_score : '0;
   assign out_score1 = s1_v ? s1_score : '0;
   assign out_cnt    = {1'b0, s0_v} + {1'b0, s1_v};
   assign err_drop   = err_q;
   assign dbg_state  = state;

endmodule

// File: tb/tb_moe_topk_gate.sv
module tb_moe_topk_gate;

   localparam int N  = 16;
   localparam int LW = 16;
   localparam int IW = 4;
   localparam int W  = N * LW;

   typedef struct {
      logic [IW-1:0] idx0;
      logic [IW-1:0] idx1;
      logic [LW-1:0] s0;
      logic [LW-1:0] s1;
      logic [1:0]    cnt;
   } exp_t;

   typedef struct {
      logic [W-1:0] vec;
      logic [N-1:0] mask;
      exp_t         exp;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [W-1:0]  in_sum = '0;
   logic [N-1:0]  in_mask = '0;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [IW-1:0] out_idx0, out_idx1;
   logic [LW-1:0] out_score0, out_score1;
   logic [1:0]    out_cnt;
   logic          err_drop;
   logic [1:0]    dbg_state;

   int n_tests = 0;
   int n_fail  = 0;
   logic exp_err = 1'b0;

   moe_topk_gate #(.NUM_LANES(N), .LANE_W(LW), .IDX_W(IW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sum(in_sum),
      .in_mask(in_mask), .in_ready(in_ready), .out_valid(out_valid),
      .out_ready(out_ready), .out_idx0(out_idx0), .out_idx1(out_idx1),
      .out_score0(out_score0), .out_score1(out_score1), .out_cnt(out_cnt),
      .err_drop(err_drop), .dbg_state(dbg_state)
   );

   // Clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: pick the largest enabled logit (lowest lane on ties),
   // then the largest remaining one.
   function automatic exp_t model(input logic [W-1:0] v, input logic [N-1:0] m);
      exp_t e;
      int   best, second;
      int   val[N];
      for (int i = 0; i < N; i++) val[i] = int'($signed(v[i*LW +: LW]));
      best = -1;
      second = -1;
      for (int i = 0; i < N; i++)
         if (m[i] && (best < 0 || val[i] > val[best])) best = i;
      for (int i = 0; i < N; i++)
         if (m[i] && i != best && (second < 0 || val[i] > val[second])) second = i;
      e.idx0 = (best >= 0) ? IW'(best) : '0;
      e.s0   = (best >= 0) ? LW'(val[best]) : '0;
      e.idx1 = (second >= 0) ? IW'(second) : '0;
      e.s1   = (second >= 0) ? LW'(val[second]) : '0;
      e.cnt  = 2'((best >= 0) + (second >= 0));
      return e;
   endfunction

   function automatic logic [W-1:0] pack_lane(input logic [W-1:0] v, input int i, input logic [LW-1:0] x);
      logic [W-1:0] r;
      r = v;
      r[i*LW +: LW] = x;
      return r;
   endfunction

   // Driver: wait for in_ready, present one vector for one cycle.
   task automatic drive(input logic [W-1:0] v, input logic [N-1:0] m);
      int t;
      t = 0;
      while (!in_ready && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         check("drive_ready_timeout", 32'(in_ready), 32'd1);
         return;
      end
      in_valid = 1'b1;
      in_sum   = v;
      in_mask  = m;
      @(negedge clk);
      in_valid = 1'b0;
      in_sum   = {W{1'b1}};
      in_mask  = {N{1'b1}};
   endtask

   task automatic check_result(input string tag, input exp_t e);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_cnt"}, 32'(out_cnt), 32'(e.cnt));
      check({tag, "_idx0"}, 32'(out_idx0), 32'(e.idx0));
      check({tag, "_idx1"}, 32'(out_idx1), 32'(e.idx1));
      check({tag, "_score0"}, 32'(out_score0), 32'(e.s0));
      check({tag, "_score1"}, 32'(out_score1), 32'(e.s1));
   endtask

   // Call right after drive(). Checks latency, result, hold stability and
   // release. pulse_at >= 0 injects an illegal in_valid pulse during SCAN.
   task automatic await_result(input string tag, input exp_t e, input int hold, input int pulse_at);
      int lat;
      lat = 0;
      while (!out_valid && lat < 40) begin
         if (lat == pulse_at) begin
            in_valid = 1'b1;
            in_sum   = {W{1'b1}};
            in_mask  = {N{1'b1}};
            exp_err  = 1'b1;
         end
         @(negedge clk);
         in_valid = 1'b0;
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(N));
      if (!out_valid) return;
      check_result(tag, e);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check_result({tag, "_hold"}, e);
      end
      check({tag, "_err_drop"}, 32'(err_drop), 32'(exp_err));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_release_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_release_ready"}, 32'(in_ready), 32'd1);
   endtask

   vec_t tbl[7];

   initial begin
      logic [W-1:0] v;
      logic [N-1:0] m;
      exp_t e;
      int   gap;

      // Vector table
      v = '0;
      for (int i = 0; i < N; i++) v = pack_lane(v, i, LW'(i * 10));
      tbl[0] = '{vec: v, mask: 16'hFFFF, exp: '{idx0: 4'd15, idx1: 4'd14, s0: 16'd150, s1: 16'd140, cnt: 2'd2}};
      tbl[1] = '{vec: v, mask: 16'h00FF, exp: '{idx0: 4'd7, idx1: 4'd6, s0: 16'd70, s1: 16'd60, cnt: 2'd2}};
      v = '0;
      for (int i = 0; i < N; i++) v = pack_lane(v, i, 16'hFFFB);
      v = pack_lane(v, 3, 16'h7FFF);
      v = pack_lane(v, 9, 16'h7FFF);
      tbl[2] = '{vec: v, mask: 16'hFFFF, exp: '{idx0: 4'd3, idx1: 4'd9, s0: 16'h7FFF, s1: 16'h7FFF, cnt: 2'd2}};
      v = '0;
      for (int i = 0; i < N; i++) v = pack_lane(v, i, 16'hFF9C);
      v = pack_lane(v, 7, 16'hFFFF);
      v = pack_lane(v, 2, 16'hFFFE);
      tbl[3] = '{vec: v, mask: 16'hFFFF, exp: '{idx0: 4'd7, idx1: 4'd2, s0: 16'hFFFF, s1: 16'hFFFE, cnt: 2'd2}};
      v = {W{1'b1}};
      v = pack_lane(v, 4, 16'd42);
      tbl[4] = '{vec: v, mask: 16'h0010, exp: '{idx0: 4'd4, idx1: 4'd0, s0: 16'd42, s1: 16'd0, cnt: 2'd1}};
      tbl[5] = '{vec: v, mask: 16'h0000, exp: '{idx0: 4'd0, idx1: 4'd0, s0: 16'd0, s1: 16'd0, cnt: 2'd0}};
      v = '0;
      v = pack_lane(v, 0, 16'h8000);
      v = pack_lane(v, 15, 16'h8000);
      tbl[6] = '{vec: v, mask: 16'h8001, exp: '{idx0: 4'd0, idx1: 4'd15, s0: 16'h8000, s1: 16'h8000, cnt: 2'd2}};

      // Reset
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_cnt", 32'(out_cnt), 32'd0);
      check("reset_err", 32'(err_drop), 32'd0);
      check("reset_state", 32'(dbg_state), 32'd0);

      // Table-driven vectors
      for (int k = 0; k < 7; k++) begin
         drive(tbl[k].vec, tbl[k].mask);
         await_result($sformatf("tbl%0d", k), tbl[k].exp, (k == 0) ? 5 : 1, -1);
      end

      // Illegal in_valid pulse during SCAN
      drive(tbl[0].vec, tbl[0].mask);
      await_result("drop", tbl[0].exp, 2, 4);

      // Reset while examining lane 8
      drive(tbl[2].vec, tbl[2].mask);
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_err = 1'b0;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_err", 32'(err_drop), 32'd0);
      check("midrst_cnt", 32'(out_cnt), 32'd0);
      check("midrst_score0", 32'(out_score0), 32'd0);
      drive(tbl[3].vec, tbl[3].mask);
      await_result("postrst", tbl[3].exp, 0, -1);

      // Back-to-back with out_ready held high: 18-cycle throughput
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_sum   = tbl[0].vec;
      in_mask  = tbl[0].mask;
      @(negedge clk);
      in_valid = 1'b0;
      gap = 0;
      while (!in_ready && gap < 40) begin
         @(negedge clk);
         gap++;
      end
      check("b2b_gap", 32'(gap), 32'd17);
      in_valid = 1'b1;
      in_sum   = tbl[3].vec;
      in_mask  = tbl[3].mask;
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b0;
      await_result("b2b_second", tbl[3].exp, 0, -1);
      check("b2b_err", 32'(err_drop), 32'd0);

      // Randomized vectors against the model
      for (int r = 0; r < 24; r++) begin
         v = '0;
         for (int i = 0; i < N; i++)
            v = pack_lane(v, i, (r % 2 == 0) ? LW'($urandom) : LW'($urandom_range(0, 4) - 2));
         m = N'($urandom);
         if (r % 6 == 5) m = N'(1 << $urandom_range(0, N - 1));
         e = model(v, m);
         drive(v, m);
         await_result($sformatf("rnd%0d", r), e, $urandom_range(0, 3), -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
